mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle RV32M multiply/divide unit. It sits in the EX stage beside the single-cycle ALU.
- The ALU answers combinationally in one cycle. This block accepts a request, holds the pipeline via busy_o, and returns one result through a valid/ready handshake.
- Operand forwarding and the decode of md_op_i live upstream. The EX/MEM writeback mux consumes result_o.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must hold the value XLEN.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request valid; accepted only when ready_o=1.
- md_op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  32  rs1 operand.
- b_i  in  32  rs2 operand.
- flush_i  in  1  pipeline flush; abandons any operation in progress.
- ready_i  in  1  downstream accepts result.
- ready_o  out  1  idle, request can be accepted.
- busy_o  out  1  operation in flight; drives the stall to the hazard unit.
- valid_o  out  1  result_o is valid.
- result_o  out  32  result.

Behaviour:
- Reset (async, rst_n_i=0): state IDLE, counter 0, internal registers 0, valid_o=0, busy_o=0, ready_o=1, result_o=0. Reset mid-operation discards the operation with no output.
- State IDLE:
  - ready_o=1, busy_o=0, valid_o=0.
  - If start_i=1 and flush_i=0, latch md_op_i, a_i and b_i, then:
    - special-case divide → DONE;
    - any other op → CALC with counter=0.
- State CALC:
  - busy_o=1, ready_o=0. One iteration per cycle; after iteration XLEN-1 → DONE.
  - Request accepted at edge k gives valid_o=1 from cycle k+33.
- State DONE:
  - valid_o=1, busy_o=1, result_o stable.
  - If ready_i=1 → IDLE. Otherwise hold DONE with no change to result_o.
  - A new request can be accepted only in IDLE, so back-to-back ops have a one-cycle gap.
- flush_i=1 in any state forces IDLE at the next edge and suppresses valid_o. flush_i wins over start_i and over ready_i in the same cycle.
- Signed handling:
  - Signed operands (DIV, REM, MULH both; MULHSU a_i only) are converted to magnitudes before iterating.
  - After the last iteration the result sign is fixed: product/quotient negated when operand signs differ; remainder takes the sign of the dividend.
- Multiply: shift-add over a 64-bit accumulator. MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] of the sign-corrected 64-bit product.
- Divide: restoring, 1 quotient bit per iteration, 33-bit partial remainder.
- Special cases (1-cycle path, valid_o at k+1):
  - b_i=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a_i.
  - DIV with a_i=0x80000000 and b_i=0xFFFFFFFF → 0x80000000; REM in the same case → 0.
- result_o updates only on entry to DONE and holds its value in IDLE until the next completion.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit signed/unsigned product and go IDLE → DONE directly, valid_o at k+1. Divides are unchanged at 33 cycles.
- Undefined: all multiplies use the iterative path, valid_o at k+33.

Test Plan:
- MUL a=7, b=6, ready_i=1 → valid_o one cycle at k+33 (k+1 with MDU_FAST_MUL_EN), result 0x0000002A, then ready_o=1.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU with the same operands → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF at k+1. REM a=5, b=0 → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at k+1.
- DIV started, flush_i pulsed at cycle k+10 → IDLE at k+11, valid_o never asserted. A following DIVU 9/3 → 3.
- ready_i held 0 for 5 cycles in DONE → valid_o and result_o stable and start_i ignored. Assert rst_n_i=0 mid-CALC → all outputs at reset values immediately.

Source files
------------

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MDU_FAST_MUL_EN: single-cycle multiplies, divides stay iterative.
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t              r_state, w_state_nx;
  logic [2:0]          r_op;
  logic                r_neg;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_opb;
  logic [XLEN-1:0]     r_res;

  // ---- request decode (used only while IDLE) ----
  logic            w_accept, w_in_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_special;
  logic [XLEN-1:0] w_spec_res;

  assign w_accept = start_i && !flush_i;
  assign w_in_div = md_op_i[2];
  assign w_a_sgn  = (md_op_i == OP_MULH) || (md_op_i == OP_MULHSU) ||
                    (md_op_i == OP_DIV)  || (md_op_i == OP_REM);
  assign w_b_sgn  = (md_op_i == OP_MULH) || (md_op_i == OP_DIV) || (md_op_i == OP_REM);
  assign w_a_neg  = w_a_sgn && a_i[XLEN-1];
  assign w_b_neg  = w_b_sgn && b_i[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~a_i + 1'b1) : a_i;
  assign w_b_mag  = w_b_neg ? (~b_i + 1'b1) : b_i;
  // Remainder follows the dividend; products and quotients follow the sign XOR.
  assign w_neg    = (md_op_i == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  always_comb begin
    w_special  = 1'b0;
    w_spec_res = '0;
    if (w_in_div) begin
      if (b_i == '0) begin
        w_special  = 1'b1;
        w_spec_res = md_op_i[1] ? a_i : ALL_ONE;
      end else if (((md_op_i == OP_DIV) || (md_op_i == OP_REM)) &&
                   (a_i == MIN_NEG) && (b_i == ALL_ONE)) begin
        w_special  = 1'b1;
        w_spec_res = md_op_i[1] ? '0 : MIN_NEG;
      end
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fast_p;
  logic        [XLEN-1:0]   w_fast_res;
  assign w_fast_p   = $signed({w_a_sgn & a_i[XLEN-1], a_i}) *
                      $signed({w_b_sgn & b_i[XLEN-1], b_i});
  assign w_fast_res = (md_op_i == OP_MUL) ? w_fast_p[XLEN-1:0] : w_fast_p[2*XLEN-1:XLEN];
`endif

  // ---- one iteration step ----
  // Multiply: r_acc = {partial, multiplier}; add multiplicand into the top half then shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_mul;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_acc_mul = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: r_acc[XLEN-1:0] shifts the dividend out and the quotient in.
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub, w_rem_nx, w_quo_nx;
  assign w_rem_sh = {r_rem, r_acc[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_opb});
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_opb;
  assign w_rem_nx = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
  assign w_quo_nx = {r_acc[XLEN-2:0], w_ge};

  logic w_last;
  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  // Sign correction applied on the final step, straight into the result register.
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fin_res;
  assign w_prod_s = r_neg ? (~w_acc_mul + 1'b1) : w_acc_mul;
  assign w_quo_s  = r_neg ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_rem_s  = r_neg ? (~w_rem_nx + 1'b1) : w_rem_nx;

  always_comb begin
    w_fin_res = '0;
    if (r_op[2])             w_fin_res = r_op[1] ? w_rem_s : w_quo_s;
    else if (r_op == OP_MUL) w_fin_res = w_prod_s[XLEN-1:0];
    else                     w_fin_res = w_prod_s[2*XLEN-1:XLEN];
  end

  // ---- control FSM ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special)      w_state_nx = S_DONE;
`ifdef MDU_FAST_MUL_EN
          else if (!w_in_div) w_state_nx = S_DONE;
`endif
          else                w_state_nx = S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i)     w_state_nx = S_IDLE;
        else if (w_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (flush_i || ready_i) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_op  <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_opb <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= md_op_i;
            r_neg <= w_neg;
            r_cnt <= '0;
            r_rem <= '0;
            r_opb <= w_in_div ? w_b_mag : w_a_mag;
            r_acc <= {{XLEN{1'b0}}, (w_in_div ? w_a_mag : w_b_mag)};
            if (w_special) r_res <= w_spec_res;
`ifdef MDU_FAST_MUL_EN
            else if (!w_in_div) r_res <= w_fast_res;
`endif
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
              r_acc <= {{XLEN{1'b0}}, w_quo_nx};
              r_rem <= w_rem_nx;
            end else begin
              r_acc <= w_acc_mul;
            end
            if (w_last) r_res <= w_fin_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = (r_state == S_DONE) && !flush_i;
  assign result_o = r_res;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: results, latency, special cases, flush, back-pressure, reset.
module tb_mdu_iter;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  md_op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .md_op_i(md_op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .ready_i(ready_i),
    .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a request at a negedge; it is taken on the following rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    check("ready_before_issue", {63'd0, ready_o}, 64'd1);
    md_op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Number of negedges after the accepting edge until valid_o is seen (100 = timeout).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!valid_o && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, {32'd0, result_o}, {32'd0, exp});
    @(negedge clk_i);
    check({tag, "_after"}, {62'd0, valid_o, ready_o}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int vcount;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_ready",  {63'd0, ready_o}, 64'd1);
    check("rst_busy",   {63'd0, busy_o},  64'd0);
    check("rst_valid",  {63'd0, valid_o}, 64'd0);
    check("rst_result", {32'd0, result_o}, 64'd0);
    rst_n_i = 1'b1;

    // Multiplies
    run_op("mul_7x6",      3'd0, 32'd7,        32'd6,        32'h0000002A, MUL_LAT);
    run_op("mul_neg",      3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, MUL_LAT);
    run_op("mulh_m1m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
    run_op("mulh_min2",    3'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, MUL_LAT);
    run_op("mulhu_ff",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu_m1_2",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);

    // Divides
    run_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    run_op("div_7_m2",     3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
    run_op("rem_7_m2",     3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT);
    run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       DIV_LAT);
    run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_op("divu_max_1",   3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT);
    run_op("remu_min_max", 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT);

    // Special cases on the one-cycle path
    run_op("divu_by0",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",      3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush in the middle of a divide
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_idle", {61'd0, busy_o, ready_o, valid_o}, 64'b010);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    check("flush_no_valid", 64'(vcount), 64'd0);
    check("flush_result_kept", {32'd0, result_o}, 64'h0);
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT);

    // Back-pressure in DONE: output holds and new requests are ignored
    ready_i = 1'b0;
    issue(3'd5, 32'd100, 32'd7);
    wait_valid(lat);
    check("hold_lat", 64'(lat), 64'(DIV_LAT));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  {63'd0, valid_o}, 64'd1);
      check("hold_result", {32'd0, result_o}, 64'd14);
      check("hold_ready",  {63'd0, ready_o}, 64'd0);
      md_op_i = 3'd0; a_i = 32'd3; b_i = 32'd3; start_i = 1'b1;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("hold_release", {61'd0, busy_o, ready_o, valid_o}, 64'b010);
    check("hold_idle_result", {32'd0, result_o}, 64'd14);

    // Asynchronous reset mid-calculation
    issue(3'd4, 32'd100, 32'd7);
    repeat (5) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("arst_outputs", {29'd0, busy_o, ready_o, valid_o, result_o}, {29'd0, 3'b010, 32'd0});
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_op("post_rst_div", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
